rr_bus_arbiter_4: RTL and testbench
===================================

# rr_bus_arbiter_4

Four-way round-robin arbiter that shares one DATA_W-bit bus between four requesters. It owns the select of an internal 4:1 bus mux and grants the bus in bursts of up to MAX_BURST beats. Each beat is handed downstream with a valid/ready handshake. It sits between four producer ports (a, b, c, d) and a single downstream consumer.

## Interface
- DATA_W, 8, width of each data input and of o_data
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration; legal range ≥1
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_req  input  4  per-requester valid; bit 0=a, 1=b, 2=c, 3=d
- i_a, i_b, i_c, i_d  input  DATA_W  requester data; must be held stable while that requester's i_req is high and no transfer has occurred
- i_ready  input  1  downstream accepts the beat this cycle
- o_gnt  output  4  one-hot grant, or 0 when idle
- o_sel  output  2  mux select, the index of the granted requester
- o_data  output  DATA_W  mux output selected by o_sel
- o_valid  output  1  beat on o_data is valid
- o_busy  output  1  a grant is active

## Operation
- States: IDLE (o_busy=0, o_gnt=0) and GRANT (o_busy=1, o_gnt=1<<o_sel).
- Registers: state, o_sel, o_gnt, last (index of the last grant), beat counter (width clog2(MAX_BURST+1)).
- Reset values: state=IDLE, o_gnt=4'b0000, o_sel=2'd0, last=2'd3, beat=0. Resulting outputs: o_busy=0, o_valid=0, o_data=i_a.
- Round-robin pick: scan i_req starting at last+1 mod 4 and wrapping. The first set bit wins. After reset, priority order is therefore 0,1,2,3.
- IDLE→GRANT: if any i_req bit is set, load o_sel=pick, last=pick, o_gnt=onehot(pick), beat=0.
- Transfer: a transfer occurs when o_valid & i_ready. Each transfer increments beat.
- o_valid = o_busy & i_req[o_sel]. Transfers count only when o_valid & i_ready; i_ready does not feed o_valid.
- Release condition in GRANT (either one):
  - transfer with beat==MAX_BURST-1 (burst complete), or
  - i_req[o_sel]==0 (requester withdrew).
- On release, re-arbitrate in the same cycle with no bubble:
  - If any i_req bit is set, take GRANT with the new pick and beat=0. The pick starts at o_sel+1, so the current holder is regranted only if no one else requests. A withdrawn requester is never regranted.
  - If no i_req bit is set, go to IDLE.
- Otherwise stay in GRANT with o_sel unchanged. If i_ready=0, the grant is held indefinitely.
- In IDLE, o_sel keeps its last value and o_data follows that input. Consumers must ignore o_data when o_valid=0.
- Asynchronous reset at any point, including mid-burst, forces all reset values immediately. Beats not yet accepted are discarded.

## Timing
- o_gnt, o_sel and o_busy are registered. o_valid and o_data are combinational from registers and inputs. There is no path from i_ready to o_valid or o_data.
- Arbitration latency: an i_req sampled at rising edge N produces o_gnt/o_valid in the cycle after edge N, i.e. one cycle.
- A full burst occupies exactly MAX_BURST cycles when i_ready=1 throughout.
- Handoff to the next requester happens at the clock edge of the releasing cycle: zero dead cycles between bursts.
- MAX_BURST=1 makes the grant rotate every accepted beat.

## Test plan
- Reset: i_rst_n=0 with i_req=4'hF → o_gnt=0, o_sel=0, o_busy=0, o_valid=0. After release, the first grant is 4'b0001 one cycle later.
- Single requester: i_req=4'b0100, i_c=8'hA5, i_ready=1 → from cycle 1, o_gnt=4'b0100, o_sel=2, o_data=8'hA5, o_valid=1 continuously. The grant renews every 4 beats with no bubble.
- Fairness: i_req=4'hF, i_ready=1, MAX_BURST=4 → o_sel sequence 0×4, 1×4, 2×4, 3×4, then 0 again; exactly 16 transfers per rotation.
- Backpressure: granted to b, i_ready=0 for 10 cycles after 1 beat → o_gnt stays 4'b0010, o_data stable, beat held at 1. After i_ready returns to 1, exactly 3 more beats, then o_sel moves to the next requester.
- Early withdrawal: b granted with i_req=4'b1010; b drops i_req[1] after 2 beats → next cycle o_gnt=4'b1000, o_sel=3. With no requests at all, the block goes to IDLE and o_busy=0.
- Mid-burst reset: pulse i_rst_n low during beat 2 of c → outputs go to reset values immediately, without waiting for an edge. After release with i_req=4'b0100, c is granted fresh with beat count 0.

Source files
------------

// File: rtl/rr_bus_arbiter_4.sv
// rr_bus_arbiter_4
//   Four-way round-robin arbiter owning a 4:1 data mux. A grant lasts up to
//   MAX_BURST accepted beats. It is released early if the holder drops its
//   request. On release the next requester is picked in the same cycle, so
//   there are no dead cycles between bursts.
// Ports
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_req[3:0]         per-requester valid (0=a, 1=b, 2=c, 3=d)
//   i_a..i_d           requester data
//   i_ready            downstream accepts the current beat
//   o_gnt[3:0]         one-hot grant, 0 when idle (registered)
//   o_sel[1:0]         mux select / granted index (registered)
//   o_data             mux output selected by o_sel
//   o_valid            beat on o_data is valid (never depends on i_ready)
//   o_busy             a grant is active (registered state)
module rr_bus_arbiter_4 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_req,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_ready,
  output logic [3:0]        o_gnt,
  output logic [1:0]        o_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  logic [1:0]    last;
  logic [BW-1:0] beat;
  logic [1:0]    pick;
  logic          any_req;
  logic          xfer;
  logic          rel;

  // Scan from last+1 upward, wrapping. Iterating from the farthest offset
  // down to the nearest lets the nearest requester overwrite the others.
  // Offset 4 wraps to last itself, so the holder wins only when alone.
  always_comb begin
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      if (i_req[last + 2'(k)]) pick = last + 2'(k);
    end
  end

  assign any_req = |i_req;
  assign o_busy  = (state == GRANT);
  assign o_valid = o_busy & i_req[o_sel];
  assign xfer    = o_valid & i_ready;
  assign rel     = o_busy & ((xfer & (beat == BW'(MAX_BURST - 1))) | ~i_req[o_sel]);

  always_comb begin
    case (o_sel)
      2'd0:    o_data = i_a;
      2'd1:    o_data = i_b;
      2'd2:    o_data = i_c;
      default: o_data = i_d;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_gnt <= 4'b0000;
      o_sel <= 2'd0;
      last  <= 2'd3;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= GRANT;
            o_sel <= pick;
            last  <= pick;
            o_gnt <= 4'b0001 << pick;
            beat  <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            if (any_req) begin
              // last == o_sel while granted, so pick already starts at o_sel+1
              o_sel <= pick;
              last  <= pick;
              o_gnt <= 4'b0001 << pick;
              beat  <= '0;
            end else begin
              state <= IDLE;
              o_gnt <= 4'b0000;
              beat  <= '0;
            end
          end else if (xfer) begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter_4.sv
module tb_rr_bus_arbiter_4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [3:0]    i_req;
  logic [DW-1:0] i_a, i_b, i_c, i_d;
  logic          i_ready;
  logic [3:0]    o_gnt;
  logic [1:0]    o_sel;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_busy;

  rr_bus_arbiter_4 #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d), .i_ready(i_ready),
    .o_gnt(o_gnt), .o_sel(o_sel), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the bus, how many beats it has been given,
  // and who was granted last.
  bit m_busy;
  int m_sel, m_last, m_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic logic [DW-1:0] din(input int s);
    case (s)
      0: return i_a;
      1: return i_b;
      2: return i_c;
      default: return i_d;
    endcase
  endfunction

  task automatic m_reset();
    m_busy = 0; m_sel = 0; m_last = 3; m_beat = 0;
  endtask

  task automatic chk_model();
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    chk("gnt",   32'(o_gnt),   32'(eg));
    chk("sel",   32'(o_sel),   32'(m_sel));
    chk("busy",  32'(o_busy),  32'(m_busy));
    chk("valid", 32'(o_valid), 32'(m_busy && i_req[m_sel]));
    chk("data",  32'(o_data),  32'(din(m_sel)));
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic m_step();
    bit xfer;
    if (!m_busy) begin
      if (i_req != 0) begin
        m_sel = pick_from((m_last + 1) % 4, i_req);
        m_last = m_sel; m_beat = 0; m_busy = 1;
      end
    end else begin
      xfer = i_req[m_sel] && i_ready;
      if ((xfer && m_beat == MB - 1) || !i_req[m_sel]) begin
        if (i_req != 0) begin
          m_sel = pick_from((m_sel + 1) % 4, i_req);
          m_last = m_sel; m_beat = 0;
        end else begin
          m_busy = 0; m_beat = 0;
        end
      end else if (xfer) m_beat++;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the next one.
  task automatic cyc(input logic [3:0] req, input logic rdy);
    i_req = req; i_ready = rdy;
    #3;
    chk_model();
    @(posedge i_clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    m_reset();
    #2;
    chk("rst_gnt",  32'(o_gnt),  32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    m_step();
    #1;
  endtask

  initial begin
    int xfers;
    i_rst_n = 1'b0; i_req = 4'hF; i_ready = 1'b1;
    i_a = 8'h11; i_b = 8'h22; i_c = 8'hA5; i_d = 8'h44;
    m_reset();

    // Reset holds everything idle even with all requests up
    #2;
    chk("reset_gnt",   32'(o_gnt),   32'h0);
    chk("reset_sel",   32'(o_sel),   32'h0);
    chk("reset_busy",  32'(o_busy),  32'h0);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_data",  32'(o_data),  32'h11);
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("reset_hold_gnt", 32'(o_gnt), 32'h0);
    i_rst_n = 1'b1;
    cyc(4'hF, 1'b1);
    chk("first_gnt", 32'(o_gnt), 32'h1);

    // Single requester c: continuous grant, renewed without bubbles
    cyc(4'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0100, 1'b1);
      chk("single_gnt",   32'(o_gnt),   32'b0100);
      chk("single_data",  32'(o_data),  32'hA5);
      chk("single_valid", 32'(o_valid), 32'h1);
    end

    // Fairness: four beats each, in order 0,1,2,3, twice round
    i_req = 4'h0;
    do_reset();
    xfers = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(4'hF, 1'b1);
      chk("fair_sel", 32'(o_sel), 32'((i / 4) % 4));
      if (o_valid) xfers++;
    end
    chk("fair_xfers", 32'(xfers), 32'd32);

    // Backpressure on b after one beat
    i_req = 4'h0;
    do_reset();
    cyc(4'b0010, 1'b1);
    cyc(4'b0110, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0110, 1'b0);
      chk("bp_gnt",  32'(o_gnt),  32'b0010);
      chk("bp_data", 32'(o_data), 32'h22);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0110, 1'b1);
      chk("bp_resume_sel", 32'(o_sel), (i < 2) ? 32'd1 : 32'd2);
    end

    // Early withdrawal of b, then d withdraws too
    i_req = 4'h0;
    do_reset();
    cyc(4'b1010, 1'b1);
    chk("wd_first", 32'(o_sel), 32'd1);
    cyc(4'b1010, 1'b1);
    cyc(4'b1010, 1'b1);
    cyc(4'b1000, 1'b1);
    chk("wd_gnt", 32'(o_gnt), 32'b1000);
    chk("wd_sel", 32'(o_sel), 32'd3);
    cyc(4'b0000, 1'b1);
    chk("wd_idle_busy", 32'(o_busy), 32'h0);
    chk("wd_idle_gnt",  32'(o_gnt),  32'h0);

    // Asynchronous reset in the middle of c's burst
    i_req = 4'h0;
    do_reset();
    cyc(4'b0100, 1'b1);
    cyc(4'b0100, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_gnt",   32'(o_gnt),   32'h0);
    chk("async_sel",   32'(o_sel),   32'h0);
    chk("async_busy",  32'(o_busy),  32'h0);
    chk("async_valid", 32'(o_valid), 32'h0);
    chk("async_data",  32'(o_data),  32'(i_a));
    m_reset();
    i_rst_n = 1'b1;
    @(posedge i_clk); m_step(); #1;
    chk("async_regrant", 32'(o_gnt), 32'b0100);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0110, 1'b1);
      chk("async_fresh_sel", 32'(o_sel), (i < 3) ? 32'd2 : 32'd1);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      i_a = DW'($urandom); i_b = DW'($urandom); i_c = DW'($urandom); i_d = DW'($urandom);
      r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = 4'h0;
      if (i % 150 == 149) begin
        i_req = r;
        do_reset();
      end else begin
        cyc(r, ($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
